fk_tap_sequencer: RTL and testbench



---
 rtl/fk_tap_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_fk_tap_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fk_tap_sequencer.sv
// ---------------------------------------------------------------------------
// fk_tap_sequencer
//
// Upstream stage of the fk tap multiplexer in the filter datapath. It keeps
// a three-deep sample history (fk = newest, fk_1 = previous, fk_2 = the one
// before that). Each accepted sample shifts that history once. The block then
// walks the mux select through taps 0, 1 and 2, one tap per handshaked
// transfer, so the downstream multiply-accumulate consumes one tap per beat.
// While idle the select rests on 2'b11, which makes the mux output zero.
//
// Optional build macro:
//   FK_FLUSH_EN  adds a 'flush' input. It clears the history while idle.
//                flush + sample_valid together loads sample_in into fk and
//                zeroes fk_1 and fk_2. flush is ignored outside IDLE, and
//                rst has priority over it.
//
// Parameters:
//   W             sample/tap width in bits (25 to match the mux datapath)
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   rst           synchronous active-high reset, overrides everything
//   sample_valid  upstream offers sample_in this cycle
//   sample_in     new sample, two's complement, stored verbatim
//   sample_ready  block can accept a sample (high only in IDLE)
//   fk            current sample register
//   fk_1          previous sample register
//   fk_2          sample two steps back register
//   sel           tap select to the mux: 00=fk, 01=fk_1, 10=fk_2, 11=idle
//   tap_valid     sel addresses a valid tap this cycle
//   tap_ready     downstream MAC accepts the current tap
//   tap_last      high with tap_valid on the final tap (sel=10)
//   flush         (FK_FLUSH_EN only) clear the history while idle
//   busy          high in any state other than IDLE
// ---------------------------------------------------------------------------
module fk_tap_sequencer #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_valid,
  input  logic [W-1:0] sample_in,
  output logic         sample_ready,
  output logic [W-1:0] fk,
  output logic [W-1:0] fk_1,
  output logic [W-1:0] fk_2,
  output logic [1:0]   sel,
  output logic         tap_valid,
  input  logic         tap_ready,
  output logic         tap_last,
`ifdef FK_FLUSH_EN
  input  logic         flush,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAP0 = 2'd1,
    TAP1 = 2'd2,
    TAP2 = 2'd3
  } state_e;

  localparam logic [1:0] SEL_FK   = 2'b00;
  localparam logic [1:0] SEL_FK1  = 2'b01;
  localparam logic [1:0] SEL_FK2  = 2'b10;
  localparam logic [1:0] SEL_IDLE = 2'b11;

  state_e       state_q;
  logic [1:0]   sel_q;
  logic         tapValid_q;
  logic         tapLast_q;
  logic         ready_q;
  logic         busy_q;

  logic [W-1:0] fk_q;
  logic [W-1:0] fk1_q;
  logic [W-1:0] fk2_q;
  logic [W-1:0] fk_d;
  logic [W-1:0] fk1_d;
  logic [W-1:0] fk2_d;

  logic         accept;
  logic         clearHist;

  // A sample is only ever taken in IDLE. This keeps the history frozen for
  // the whole tap walk, including stalls.
  assign accept = (state_q == IDLE) && sample_valid;

`ifdef FK_FLUSH_EN
  assign clearHist = (state_q == IDLE) && flush;
`else
  assign clearHist = 1'b0;
`endif

  // Next-state history. A normal accept shifts all three registers in the
  // same edge. An accept with flush keeps only the new sample. A flush
  // alone wipes the history.
  always_comb begin
    fk_d  = fk_q;
    fk1_d = fk1_q;
    fk2_d = fk2_q;
    if (accept) begin
      fk_d  = sample_in;
      fk1_d = clearHist ? '0 : fk_q;
      fk2_d = clearHist ? '0 : fk1_q;
    end else if (clearHist) begin
      fk_d  = '0;
      fk1_d = '0;
      fk2_d = '0;
    end
  end

  // History registers. Reset clears them, so a sample after a reset sees
  // zeros in the older taps.
  always_ff @(posedge clk) begin
    if (rst) begin
      fk_q  <= '0;
      fk1_q <= '0;
      fk2_q <= '0;
    end else begin
      fk_q  <= fk_d;
      fk1_q <= fk1_d;
      fk2_q <= fk2_d;
    end
  end

  // Tap sequencer. All handshake outputs are registered alongside the state.
  // Each one is loaded with the value that belongs to the state being
  // entered, so the outputs never glitch. Without tap_ready, a TAPn state
  // leaves every register untouched, which gives the stall behaviour. The
  // TAP2 transfer returns to IDLE with sample_ready already high, so the
  // next sample can be taken in the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= SEL_IDLE;
      tapValid_q <= 1'b0;
      tapLast_q  <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sample_valid) begin
            state_q    <= TAP0;
            sel_q      <= SEL_FK;
            tapValid_q <= 1'b1;
            tapLast_q  <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        TAP0: begin
          if (tap_ready) begin
            state_q <= TAP1;
            sel_q   <= SEL_FK1;
          end
        end
        TAP1: begin
          if (tap_ready) begin
            state_q   <= TAP2;
            sel_q     <= SEL_FK2;
            tapLast_q <= 1'b1;
          end
        end
        TAP2: begin
          if (tap_ready) begin
            state_q    <= IDLE;
            sel_q      <= SEL_IDLE;
            tapValid_q <= 1'b0;
            tapLast_q  <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          sel_q      <= SEL_IDLE;
          tapValid_q <= 1'b0;
          tapLast_q  <= 1'b0;
          ready_q    <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign sample_ready = ready_q;
  assign fk           = fk_q;
  assign fk_1         = fk1_q;
  assign fk_2         = fk2_q;
  assign sel          = sel_q;
  assign tap_valid    = tapValid_q;
  assign tap_last     = tapLast_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_fk_tap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fk_tap_sequencer
//
// Self-checking bench for fk_tap_sequencer. It runs a table of directed
// vectors with hand-derived expectations, then a few hand-written multi-cycle
// sequences, then a randomized run. A reference model checks every cycle.
// The model is a three-entry history array plus an integer tap index
// (-1 when idle).
// ---------------------------------------------------------------------------
module tb_fk_tap_sequencer;

  localparam int W = 25;

  logic         clk;
  logic         rst;
  logic         sample_valid;
  logic [W-1:0] sample_in;
  logic         sample_ready;
  logic [W-1:0] fk;
  logic [W-1:0] fk_1;
  logic [W-1:0] fk_2;
  logic [1:0]   sel;
  logic         tap_valid;
  logic         tap_ready;
  logic         tap_last;
  logic         flushIn;
  logic         busy;

  int errCount;
  int checkCount;

  // Reference model state.
  logic [W-1:0] mHist[3];
  int           mPhase;

  fk_tap_sequencer #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample_in   (sample_in),
    .sample_ready(sample_ready),
    .fk          (fk),
    .fk_1        (fk_1),
    .fk_2        (fk_2),
    .sel         (sel),
    .tap_valid   (tap_valid),
    .tap_ready   (tap_ready),
    .tap_last    (tap_last),
`ifdef FK_FLUSH_EN
    .flush       (flushIn),
`endif
    .busy        (busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic         r;
    logic         sv;
    logic [W-1:0] d;
    logic         tr;
    logic [W-1:0] eFk;
    logic [W-1:0] eFk1;
    logic [W-1:0] eFk2;
    logic [1:0]   eSel;
    logic         eTv;
    logic         eTl;
    logic         eSr;
    logic         eBusy;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic r, input logic sv, input logic [W-1:0] d,
                                 input logic tr, input logic [W-1:0] eFk,
                                 input logic [W-1:0] eFk1, input logic [W-1:0] eFk2,
                                 input logic [1:0] eSel, input logic eTv, input logic eTl,
                                 input logic eSr, input logic eBusy);
    vec_t v;
    v.r = r; v.sv = sv; v.d = d; v.tr = tr;
    v.eFk = eFk; v.eFk1 = eFk1; v.eFk2 = eFk2; v.eSel = eSel;
    v.eTv = eTv; v.eTl = eTl; v.eSr = eSr; v.eBusy = eBusy;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // The model follows the behavioural rules directly. Reset clears
  // everything. In idle, a valid sample is pushed onto the front of the
  // history (or replaces it when flushing) and the tap walk starts at index
  // 0. A flush alone clears the history. During the walk, each tap_ready
  // moves to the next tap index, and after index 2 the model returns to idle.
  task automatic modelStep(input logic r, input logic sv, input logic [W-1:0] d,
                           input logic tr, input logic fl);
    logic flushEff;
`ifdef FK_FLUSH_EN
    flushEff = fl;
`else
    flushEff = 1'b0;
    if (fl) flushEff = 1'b0;
`endif
    if (r) begin
      for (int i = 0; i < 3; i++) mHist[i] = '0;
      mPhase = -1;
    end else if (mPhase < 0) begin
      if (sv) begin
        mHist[2] = flushEff ? '0 : mHist[1];
        mHist[1] = flushEff ? '0 : mHist[0];
        mHist[0] = d;
        mPhase   = 0;
      end else if (flushEff) begin
        for (int i = 0; i < 3; i++) mHist[i] = '0;
      end
    end else if (tr) begin
      mPhase = (mPhase == 2) ? -1 : mPhase + 1;
    end
  endtask

  task automatic checkModel();
    checkOutput("model.fk",   32'(fk),   32'(mHist[0]));
    checkOutput("model.fk_1", 32'(fk_1), 32'(mHist[1]));
    checkOutput("model.fk_2", 32'(fk_2), 32'(mHist[2]));
    checkOutput("model.sel",  32'(sel),  (mPhase < 0) ? 32'd3 : 32'(mPhase));
    checkOutput("model.tap_valid",    32'(tap_valid),    32'(mPhase >= 0));
    checkOutput("model.tap_last",     32'(tap_last),     32'(mPhase == 2));
    checkOutput("model.sample_ready", 32'(sample_ready), 32'(mPhase < 0));
    checkOutput("model.busy",         32'(busy),         32'(mPhase >= 0));
  endtask

  // Drive one cycle of inputs, step the model on the edge, then compare the
  // settled outputs 1 time unit later.
  task automatic applyStimulus(input logic r, input logic sv, input logic [W-1:0] d,
                               input logic tr, input logic fl);
    rst          = r;
    sample_valid = sv;
    sample_in    = d;
    tap_ready    = tr;
    flushIn      = fl;
    @(posedge clk);
    modelStep(r, sv, d, tr, fl);
    #1;
    checkModel();
  endtask

  task automatic checkHist(input string name, input logic [W-1:0] e0,
                           input logic [W-1:0] e1, input logic [W-1:0] e2);
    checkOutput({name, ".fk"},   32'(fk),   32'(e0));
    checkOutput({name, ".fk_1"}, 32'(fk_1), 32'(e1));
    checkOutput({name, ".fk_2"}, 32'(fk_2), 32'(e2));
  endtask

  initial begin
    errCount     = 0;
    checkCount   = 0;
    mPhase       = -1;
    for (int i = 0; i < 3; i++) mHist[i] = '0;
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    tap_ready    = 1'b0;
    flushIn      = 1'b0;

    // Directed vectors:
    //     r  sv  d            tr   fk         fk_1       fk_2   sel  tv tl sr busy
    addVec(1, 0, 25'h0,        1, 25'h0,       25'h0,       25'h0, 2'b11, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++)
      addVec(0, 0, 25'h0,      1, 25'h0,       25'h0,       25'h0, 2'b11, 0, 0, 1, 0);
    addVec(0, 1, 25'h1,        1, 25'h1,       25'h0,       25'h0, 2'b00, 1, 0, 0, 1);
    addVec(0, 1, 25'h2,        1, 25'h1,       25'h0,       25'h0, 2'b01, 1, 0, 0, 1);
    addVec(0, 1, 25'h2,        1, 25'h1,       25'h0,       25'h0, 2'b10, 1, 1, 0, 1);
    addVec(0, 1, 25'h2,        1, 25'h1,       25'h0,       25'h0, 2'b11, 0, 0, 1, 0);
    addVec(0, 1, 25'h2,        1, 25'h2,       25'h1,       25'h0, 2'b00, 1, 0, 0, 1);
    addVec(0, 1, 25'h3,        1, 25'h2,       25'h1,       25'h0, 2'b01, 1, 0, 0, 1);
    addVec(0, 1, 25'h3,        1, 25'h2,       25'h1,       25'h0, 2'b10, 1, 1, 0, 1);
    addVec(0, 1, 25'h3,        1, 25'h2,       25'h1,       25'h0, 2'b11, 0, 0, 1, 0);
    addVec(0, 1, 25'h3,        1, 25'h3,       25'h2,       25'h1, 2'b00, 1, 0, 0, 1);
    addVec(0, 0, 25'h0,        1, 25'h3,       25'h2,       25'h1, 2'b01, 1, 0, 0, 1);
    addVec(0, 0, 25'h0,        1, 25'h3,       25'h2,       25'h1, 2'b10, 1, 1, 0, 1);
    addVec(0, 0, 25'h0,        1, 25'h3,       25'h2,       25'h1, 2'b11, 0, 0, 1, 0);
    // All-ones sample, then a three-cycle stall in TAP1 with a competing sample.
    addVec(0, 1, 25'h1FFFFFF,  0, 25'h1FFFFFF, 25'h3,       25'h2, 2'b00, 1, 0, 0, 1);
    addVec(0, 0, 25'h0,        1, 25'h1FFFFFF, 25'h3,       25'h2, 2'b01, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      addVec(0, 1, 25'h5,      0, 25'h1FFFFFF, 25'h3,       25'h2, 2'b01, 1, 0, 0, 1);
    addVec(0, 1, 25'h5,        1, 25'h1FFFFFF, 25'h3,       25'h2, 2'b10, 1, 1, 0, 1);
    addVec(0, 1, 25'h5,        1, 25'h1FFFFFF, 25'h3,       25'h2, 2'b11, 0, 0, 1, 0);
    addVec(0, 1, 25'h5,        1, 25'h5,       25'h1FFFFFF, 25'h3, 2'b00, 1, 0, 0, 1);
    addVec(0, 0, 25'h0,        1, 25'h5,       25'h1FFFFFF, 25'h3, 2'b01, 1, 0, 0, 1);
    addVec(0, 0, 25'h0,        1, 25'h5,       25'h1FFFFFF, 25'h3, 2'b10, 1, 1, 0, 1);
    addVec(0, 0, 25'h0,        1, 25'h5,       25'h1FFFFFF, 25'h3, 2'b11, 0, 0, 1, 0);

    $display("[TB] directed table: %0d vectors", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].sv, vecs[i].d, vecs[i].tr, 1'b0);
      checkHist($sformatf("vec%0d", i), vecs[i].eFk, vecs[i].eFk1, vecs[i].eFk2);
      checkOutput($sformatf("vec%0d.sel", i),       32'(sel),          32'(vecs[i].eSel));
      checkOutput($sformatf("vec%0d.tap_valid", i), 32'(tap_valid),    32'(vecs[i].eTv));
      checkOutput($sformatf("vec%0d.tap_last", i),  32'(tap_last),     32'(vecs[i].eTl));
      checkOutput($sformatf("vec%0d.ready", i),     32'(sample_ready), 32'(vecs[i].eSr));
      checkOutput($sformatf("vec%0d.busy", i),      32'(busy),         32'(vecs[i].eBusy));
    end

    // Reset in the middle of TAP1 abandons the walk and clears the history.
    $display("[TB] reset during TAP1");
    applyStimulus(0, 1, 25'h0ABCDEF, 1, 0);
    applyStimulus(0, 0, 25'h0, 1, 0);
    checkOutput("midrst.sel_tap1", 32'(sel), 32'd1);
    applyStimulus(1, 1, 25'h1234567, 1, 0);
    checkHist("midrst.after", 25'h0, 25'h0, 25'h0);
    checkOutput("midrst.sel",       32'(sel),          32'd3);
    checkOutput("midrst.tap_valid", 32'(tap_valid),    32'd0);
    checkOutput("midrst.busy",      32'(busy),         32'd0);
    checkOutput("midrst.ready",     32'(sample_ready), 32'd1);
    applyStimulus(0, 1, 25'h1234567, 1, 0);
    checkHist("midrst.load", 25'h1234567, 25'h0, 25'h0);
    checkOutput("midrst.tap0", 32'(sel), 32'd0);
    applyStimulus(0, 0, 25'h0, 1, 0);
    checkOutput("midrst.tap1", 32'(sel), 32'd1);
    applyStimulus(0, 0, 25'h0, 1, 0);
    checkOutput("midrst.tap2",  32'(sel),      32'd2);
    checkOutput("midrst.last",  32'(tap_last), 32'd1);
    applyStimulus(0, 0, 25'h0, 1, 0);
    checkOutput("midrst.idle",  32'(sel),      32'd3);

    // Stall on the final tap: tap_last and sel must hold until tap_ready.
    $display("[TB] stall in TAP2");
    applyStimulus(0, 1, 25'h0C0FFEE, 1, 0);
    applyStimulus(0, 0, 25'h0, 1, 0);
    applyStimulus(0, 0, 25'h0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 25'h0000077, 0, 0);
      checkOutput("stall2.sel",  32'(sel),      32'd2);
      checkOutput("stall2.last", 32'(tap_last), 32'd1);
      checkHist("stall2", 25'h0C0FFEE, 25'h1234567, 25'h0);
    end
    applyStimulus(0, 0, 25'h0, 1, 0);
    checkOutput("stall2.idle", 32'(sample_ready), 32'd1);

`ifdef FK_FLUSH_EN
    // Flush clears the history in idle; flush plus a sample keeps only that sample.
    $display("[TB] flush sequence");
    for (int s = 7; s <= 9; s++) begin
      applyStimulus(0, 1, W'(s), 1, 0);
      for (int t = 0; t < 3; t++) applyStimulus(0, 0, 25'h0, 1, 0);
    end
    checkHist("flush.loaded", 25'h9, 25'h8, 25'h7);
    applyStimulus(0, 0, 25'h0, 1, 1);
    checkHist("flush.cleared", 25'h0, 25'h0, 25'h0);
    checkOutput("flush.sel", 32'(sel), 32'd3);
    applyStimulus(0, 1, 25'h000000A, 1, 1);
    checkHist("flush.load", 25'hA, 25'h0, 25'h0);
    checkOutput("flush.tap0", 32'(sel), 32'd0);
    applyStimulus(0, 0, 25'h0, 1, 1);
    checkOutput("flush.tap1", 32'(sel), 32'd1);
    checkHist("flush.ignored", 25'hA, 25'h0, 25'h0);
    applyStimulus(0, 0, 25'h0, 1, 0);
    checkOutput("flush.tap2", 32'(sel), 32'd2);
    applyStimulus(0, 0, 25'h0, 1, 0);
    checkOutput("flush.idle", 32'(sel), 32'd3);
`endif

    // Randomized traffic against the model, with occasional resets.
    $display("[TB] random phase");
    for (int n = 0; n < 600; n++) begin
      logic r, sv, tr, fl;
      logic [W-1:0] d;
      r  = ($urandom_range(0, 59) == 0);
      sv = ($urandom_range(0, 2) != 0);
      tr = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 7) == 0);
      d  = W'($urandom);
      applyStimulus(r, sv, d, tr, fl);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
